mole_game_sequencer: RTL and testbench
======================================

Name: mole_game_sequencer

Overview:
- Top-level round controller for the whack-a-mole game.
- Sequences game_state (idle, countdown, playing, game over) and issues the mole-spawn tick that drives the mole handler's active clock.
- Tracks score, difficulty level and remaining time.
- Sits between the button/debounce logic and the mole handler/display blocks; sole owner of game_state.

Parameters:
- TICKS_PER_SEC, 100000000, clock_i cycles per game second.
- COUNTDOWN_SEC, 3, length of pre-round countdown in seconds (1..15).
- GAME_SEC, 60, round length in seconds (1..99).
- START_PERIOD, 100000000, clock_i cycles between mole spawns at level 0.
- MIN_PERIOD, 25000000, spawn period floor.
- PERIOD_STEP, 5000000, spawn period reduction per level-up.
- HITS_PER_LEVEL, 5, whacks needed to advance one level.

Ports:
- clock_i  input  1  system clock
- reset_i  input  1  synchronous reset, active-low
- start_i  input  1  single-cycle start request (debounced)
- whacked_i  input  1  single-cycle pulse: player hit the lit mole
- miss_i  input  1  single-cycle pulse: player hit an unlit hole
- game_state  output  2  00 IDLE, 01 COUNTDOWN, 10 PLAYING, 11 OVER
- mole_tick_o  output  1  one-cycle spawn pulse to mole handler
- score_o  output  8  hit count, saturating
- level_o  output  4  difficulty level, saturating at 15
- time_left_o  output  7  seconds remaining in current phase

Behaviour:
- Reset (reset_i=0 at posedge clock_i):
  - game_state=00, mole_tick_o=0, score_o=0, level_o=0, time_left_o=0.
  - All internal counters cleared; spawn period=START_PERIOD.
  - Reset wins over every other input in any state, including mid-round.
- Second counter:
  - Counts 0..TICKS_PER_SEC-1 only in COUNTDOWN and PLAYING.
  - Internal sec_tick asserts on the wrap cycle.
  - Cleared on every state entry.
- IDLE:
  - start_i=1 -> COUNTDOWN next cycle, time_left_o=COUNTDOWN_SEC.
  - Other inputs ignored.
- COUNTDOWN:
  - On each sec_tick, time_left_o decrements.
  - sec_tick while time_left_o=1 -> PLAYING. On entry: time_left_o=GAME_SEC, score_o=0, level_o=0, period=START_PERIOD, spawn counter=0, hit counter=0, mole_tick_o=1 for exactly that first PLAYING cycle.
  - whacked_i, miss_i and start_i are ignored.
- PLAYING:
  - Spawn counter increments every cycle. At period-1 it wraps to 0 and mole_tick_o pulses for one cycle.
  - whacked_i=1:
    - score_o+1, saturating at 255.
    - Hit counter +1.
    - Spawn counter reset to 0; mole_tick_o pulses on the following cycle.
    - A natural wrap on the same cycle yields a single pulse, never two back-to-back.
  - Hit counter reaching HITS_PER_LEVEL:
    - Hit counter clears to 0.
    - level_o+1 (saturating at 15).
    - period=max(period-PERIOD_STEP, MIN_PERIOD). Use a compare-before-subtract so no underflow occurs.
    - New period takes effect at the next spawn-counter wrap/reset.
  - sec_tick: time_left_o decrements.
  - sec_tick while time_left_o=1 -> OVER, time_left_o=0.
  - whacked_i on the same cycle as that final sec_tick is still scored. No mole_tick_o is issued after entering OVER.
  - start_i is ignored while PLAYING.
- OVER:
  - score_o and level_o held; mole_tick_o=0.
  - start_i=1 -> COUNTDOWN with time_left_o=COUNTDOWN_SEC. score_o and level_o clear on PLAYING entry, not before.
- Latency: all outputs are registered; one-cycle latency from any input to its effect.
- Widths: period register sized for START_PERIOD. All arithmetic is unsigned; no output ever wraps.

Optional Feature:
- Macro: MOLE_MISS_PENALTY_EN.
- Defined: in PLAYING, miss_i=1 decrements score_o, saturating at 0. whacked_i and miss_i on the same cycle leave score_o unchanged. The hit counter still increments for the whack.
- Undefined: miss_i is ignored entirely; the port remains for interface compatibility.

Test Plan (TICKS_PER_SEC=10, COUNTDOWN_SEC=2, GAME_SEC=3, START_PERIOD=8, MIN_PERIOD=4, PERIOD_STEP=3, HITS_PER_LEVEL=2):
- Reset, then start_i pulse -> game_state=01, time_left_o=2; 20 cycles later game_state=10, time_left_o=3, mole_tick_o high exactly one cycle.
- PLAYING with no input -> mole_tick_o pulses every 8 cycles; after 30 cycles game_state=11, time_left_o=0, no further ticks.
- Two whacks -> score_o=2, level_o=1, period 5. Two more -> level_o=2, period clamped to 4; spawn spacing measured as 5 then 4.
- whacked_i coincident with natural spawn wrap -> one mole_tick_o pulse only; whacked_i on the final sec_tick -> score counted and state=11.
- reset_i low mid-PLAYING with score_o=3 -> next cycle all outputs 0, state=00. start_i during PLAYING -> no effect.
- With MOLE_MISS_PENALTY_EN: score_o=1, miss, miss -> score_o=0, 0. Without the macro: score_o stays 1.

Source files
------------

// File: rtl/mole_game_sequencer.sv
// Round controller for the whack-a-mole game. This block alone drives game_state. It runs the
// countdown and play timers and sends spawn ticks to the mole handler. It also keeps score and
// difficulty level.
// Optional feature: define MOLE_MISS_PENALTY_EN so that a miss in PLAYING costs one point.
module mole_game_sequencer #(
    parameter int unsigned TICKS_PER_SEC  = 100000000,
    parameter int unsigned COUNTDOWN_SEC  = 3,
    parameter int unsigned GAME_SEC       = 60,
    parameter int unsigned START_PERIOD   = 100000000,
    parameter int unsigned MIN_PERIOD     = 25000000,
    parameter int unsigned PERIOD_STEP    = 5000000,
    parameter int unsigned HITS_PER_LEVEL = 5
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic       whacked_i,
    input  logic       miss_i,
    output logic [1:0] game_state,
    output logic       mole_tick_o,
    output logic [7:0] score_o,
    output logic [3:0] level_o,
    output logic [6:0] time_left_o
);

    localparam int unsigned SecW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int unsigned PerW = $clog2(START_PERIOD + 1);
    localparam int unsigned HitW = $clog2(HITS_PER_LEVEL + 1);

    localparam logic [SecW-1:0] SecMax   = SecW'(TICKS_PER_SEC - 1);
    localparam logic [6:0]      CdInit   = 7'(COUNTDOWN_SEC);
    localparam logic [6:0]      GameInit = 7'(GAME_SEC);
    localparam logic [PerW-1:0] StartPer = PerW'(START_PERIOD);
    localparam logic [PerW-1:0] MinPer   = PerW'(MIN_PERIOD);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StCount = 2'b01,
        StPlay  = 2'b10,
        StOver  = 2'b11
    } state_e;

    state_e          state_q, state_d;
    logic [SecW-1:0] sec_cnt_q, sec_cnt_d;
    logic [6:0]      time_q, time_d;
    logic [7:0]      score_q, score_d;
    logic [3:0]      level_q, level_d;
    logic [HitW-1:0] hits_q, hits_d;
    logic [PerW-1:0] period_q, period_d;          // period for the current level
    logic [PerW-1:0] cur_period_q, cur_period_d;  // period of the running spawn interval
    logic [PerW-1:0] spawn_q, spawn_d;
    logic            tick_q, tick_d;

    logic            sec_tick;
    logic            spawn_wrap;
    logic [HitW-1:0] hit_inc;
    logic            level_up;
    logic [PerW-1:0] stepped_period;

`ifndef MOLE_MISS_PENALTY_EN
    logic unused_miss;
    assign unused_miss = miss_i;
`endif

    // Timing and level-up helper terms.
    always_comb begin
        sec_tick   = ((state_q == StCount) || (state_q == StPlay)) && (sec_cnt_q == SecMax);
        spawn_wrap = (spawn_q == cur_period_q - PerW'(1));
        hit_inc    = hits_q + HitW'(1);
        level_up   = (32'(hit_inc) == HITS_PER_LEVEL);
        // Compare before subtracting so the period cannot underflow.
        if (32'(period_q) >= MIN_PERIOD + PERIOD_STEP) begin
            stepped_period = PerW'(32'(period_q) - PERIOD_STEP);
        end else begin
            stepped_period = MinPer;
        end
    end

    // Next-state logic for the phase FSM, the timers and the scoring.
    always_comb begin
        state_d      = state_q;
        sec_cnt_d    = sec_cnt_q;
        time_d       = time_q;
        score_d      = score_q;
        level_d      = level_q;
        hits_d       = hits_q;
        period_d     = period_q;
        cur_period_d = cur_period_q;
        spawn_d      = spawn_q;
        tick_d       = 1'b0;
        unique case (state_q)
            StIdle, StOver: begin
                if (start_i) begin
                    state_d   = StCount;
                    time_d    = CdInit;
                    sec_cnt_d = '0;
                end
            end
            StCount: begin
                sec_cnt_d = sec_tick ? '0 : sec_cnt_q + SecW'(1);
                if (sec_tick) begin
                    if (time_q == 7'd1) begin
                        state_d      = StPlay;
                        time_d       = GameInit;
                        score_d      = '0;
                        level_d      = '0;
                        hits_d       = '0;
                        period_d     = StartPer;
                        cur_period_d = StartPer;
                        spawn_d      = '0;
                        tick_d       = 1'b1;
                    end else begin
                        time_d = time_q - 7'd1;
                    end
                end
            end
            StPlay: begin
                sec_cnt_d = sec_tick ? '0 : sec_cnt_q + SecW'(1);
                if (whacked_i) begin
                    hits_d = hit_inc;
                    if (level_up) begin
                        hits_d   = '0;
                        period_d = stepped_period;
                        if (level_q != 4'hF) begin
                            level_d = level_q + 4'd1;
                        end
                    end
                end
`ifdef MOLE_MISS_PENALTY_EN
                if (whacked_i && !miss_i && (score_q != 8'hFF)) begin
                    score_d = score_q + 8'd1;
                end else if (miss_i && !whacked_i && (score_q != 8'h00)) begin
                    score_d = score_q - 8'd1;
                end
`else
                if (whacked_i && (score_q != 8'hFF)) begin
                    score_d = score_q + 8'd1;
                end
`endif
                // A whack and a natural wrap together still yield a single pulse.
                if (whacked_i || spawn_wrap) begin
                    spawn_d      = '0;
                    cur_period_d = period_d;
                    tick_d       = 1'b1;
                end else begin
                    spawn_d = spawn_q + PerW'(1);
                end
                if (sec_tick) begin
                    if (time_q == 7'd1) begin
                        state_d   = StOver;
                        time_d    = '0;
                        sec_cnt_d = '0;
                        tick_d    = 1'b0;
                    end else begin
                        time_d = time_q - 7'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers. The synchronous reset has priority over every input.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q      <= StIdle;
            sec_cnt_q    <= '0;
            time_q       <= '0;
            score_q      <= '0;
            level_q      <= '0;
            hits_q       <= '0;
            period_q     <= StartPer;
            cur_period_q <= StartPer;
            spawn_q      <= '0;
            tick_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sec_cnt_q    <= sec_cnt_d;
            time_q       <= time_d;
            score_q      <= score_d;
            level_q      <= level_d;
            hits_q       <= hits_d;
            period_q     <= period_d;
            cur_period_q <= cur_period_d;
            spawn_q      <= spawn_d;
            tick_q       <= tick_d;
        end
    end

    assign game_state  = state_q;
    assign mole_tick_o = tick_q;
    assign score_o     = score_q;
    assign level_o     = level_q;
    assign time_left_o = time_q;

endmodule

// File: tb/tb_mole_game_sequencer.sv
// Scoreboard bench for mole_game_sequencer using small timing parameters. The driver issues one
// input set per cycle and pushes the outputs the game rules predict for the next cycle. A
// separate monitor pops each prediction and compares it after the clock edge.
module tb_mole_game_sequencer;

    localparam int unsigned TPS = 10;
    localparam int unsigned CD  = 2;
    localparam int unsigned GS  = 3;
    localparam int unsigned SP  = 8;
    localparam int unsigned MP  = 4;
    localparam int unsigned PS  = 3;
    localparam int unsigned HPL = 2;

    logic       clock_i = 1'b0;
    logic       reset_i = 1'b0;
    logic       start_i = 1'b0;
    logic       whacked_i = 1'b0;
    logic       miss_i = 1'b0;
    logic [1:0] game_state;
    logic       mole_tick_o;
    logic [7:0] score_o;
    logic [3:0] level_o;
    logic [6:0] time_left_o;

    always #5 clock_i = ~clock_i;

    mole_game_sequencer #(
        .TICKS_PER_SEC (TPS),
        .COUNTDOWN_SEC (CD),
        .GAME_SEC      (GS),
        .START_PERIOD  (SP),
        .MIN_PERIOD    (MP),
        .PERIOD_STEP   (PS),
        .HITS_PER_LEVEL(HPL)
    ) dut (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .start_i    (start_i),
        .whacked_i  (whacked_i),
        .miss_i     (miss_i),
        .game_state (game_state),
        .mole_tick_o(mole_tick_o),
        .score_o    (score_o),
        .level_o    (level_o),
        .time_left_o(time_left_o)
    );

    typedef struct packed {
        logic [1:0] st;
        logic       tick;
        logic [7:0] score;
        logic [3:0] level;
        logic [6:0] tl;
    } obs_t;

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   done  = 1'b0;

    // Game model: phase 0 idle, 1 countdown, 2 playing, 3 over.
    int phase, sub, secs, score, level, hits, per, spacing, since;
    bit tick;

    function automatic void model_step(input bit rst_n, input bit s, input bit w, input bit m);
        bit spawn;
        if (!rst_n) begin
            phase = 0; sub = 0; secs = 0; score = 0; level = 0; hits = 0;
            per = SP; spacing = SP; since = 0; tick = 0;
            return;
        end
        tick = 0;
        case (phase)
            0, 3: begin
                if (s) begin
                    phase = 1; secs = CD; sub = 0;
                end
            end
            1: begin
                sub++;
                if (sub == TPS) begin
                    sub = 0;
                    if (secs == 1) begin
                        phase = 2; secs = GS; score = 0; level = 0; hits = 0;
                        per = SP; spacing = SP; since = 0; tick = 1;
                    end else begin
                        secs--;
                    end
                end
            end
            default: begin
                since++;
                spawn = (since == spacing);
`ifdef MOLE_MISS_PENALTY_EN
                if (w && !m) score = (score < 255) ? score + 1 : 255;
                if (m && !w) score = (score > 0) ? score - 1 : 0;
`else
                if (w) score = (score < 255) ? score + 1 : 255;
`endif
                if (w) begin
                    hits++;
                    if (hits == HPL) begin
                        hits = 0;
                        level = (level < 15) ? level + 1 : 15;
                        per = (per >= int'(MP) + int'(PS)) ? per - int'(PS) : int'(MP);
                    end
                end
                if (w || spawn) begin
                    since = 0; spacing = per; tick = 1;
                end
                sub++;
                if (sub == TPS) begin
                    sub = 0;
                    if (secs == 1) begin
                        phase = 3; secs = 0; tick = 0;
                    end else begin
                        secs--;
                    end
                end
            end
        endcase
    endfunction

    task automatic cyc(input bit r, input bit s, input bit w, input bit m);
        obs_t e;
        reset_i = r; start_i = s; whacked_i = w; miss_i = m;
        model_step(r, s, w, m);
        e = '{st: 2'(phase), tick: tick, score: 8'(score), level: 4'(level), tl: 7'(secs)};
        exp_q.push_back(e);
        @(posedge clock_i);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_reset();
        n_cmp++;
        if ((game_state !== 2'b00) || (mole_tick_o !== 1'b0) || (score_o !== 8'd0) ||
            (level_o !== 4'd0) || (time_left_o !== 7'd0)) begin
            n_err++;
            $display("FAIL reset state @%0t: st=%0d tick=%0b score=%0d level=%0d time=%0d",
                     $time, game_state, mole_tick_o, score_o, level_o, time_left_o);
        end
    endtask

    // Monitor: one prediction is consumed per clock edge.
    initial begin
        obs_t e;
        obs_t a;
        forever begin
            @(posedge clock_i);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {game_state, mole_tick_o, score_o, level_o, time_left_o};
                n_cmp++;
                if (a !== e) begin
                    n_err++;
                    $display("FAIL outputs @%0t: got st=%0d tick=%0b score=%0d level=%0d time=%0d, want st=%0d tick=%0b score=%0d level=%0d time=%0d",
                             $time, a.st, a.tick, a.score, a.level, a.tl,
                             e.st, e.tick, e.score, e.level, e.tl);
                end
            end
        end
    end

    // Watchdog: the stimulus must finish within a bounded time.
    initial begin
        #1000000;
        if (!done) begin
            n_err++;
            $display("FAIL timeout @%0t: stimulus did not complete", $time);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
            $finish;
        end
    end

    initial begin
        // Reset.
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        check_reset();
        idle(3);
        // A full round with no player input, then a few cycles in OVER.
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        idle(20 + 30 + 5);
        // Level-ups, a whack on a natural wrap, and a whack on the final second.
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        idle(20);
        for (int i = 0; i < 30; i++) begin
            cyc(1'b1, 1'b0, (i == 2 || i == 3 || i == 11 || i == 12 || i == 20 || i == 29), 1'b0);
        end
        idle(4);
        // Start during PLAYING is ignored, then a reset arrives mid-round with a score of 3.
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        idle(20);
        for (int i = 0; i < 8; i++) begin
            cyc(!(i == 6), (i == 4), (i >= 1 && i <= 3), 1'b0);
        end
        idle(3);
        // Misses after one hit, plus a coincident whack and miss.
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        idle(20);
        for (int i = 0; i < 30; i++) begin
            cyc(1'b1, 1'b0, (i == 1 || i == 8), (i == 4 || i == 5 || i == 8 || i == 9));
        end
        // A whack every cycle drives the level to its ceiling.
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        idle(20);
        for (int i = 0; i < 30; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0);
        idle(3);
        // Random play.
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 299) != 0, $urandom_range(0, 14) == 0,
                $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check_reset();
        @(posedge clock_i);
        #3;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard @%0t: %0d predictions never checked", $time, exp_q.size());
        end
        done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
